// File: rtl/disp_hex_mux_cmd.sv
// Multiplexed hex display driver loaded by a framed byte command stream.
// Optional brightness control is compiled in with DISP_BRIGHTNESS_EN.
module disp_hex_mux_cmd #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 2000
) (
  input  logic                  CLK_12_MHZ,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  ssel,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            sseg,
  output logic                  cmd_error
);

  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR1  = 3'd1;
  localparam logic [2:0] S_WRA  = 3'd2;
  localparam logic [2:0] S_DISC = 3'd4;
`ifdef DISP_BRIGHTNESS_EN
  localparam logic [2:0] S_WRB  = 3'd3;
`endif

  logic [DW-1:0]         div;
  logic [PW-1:0]         ptr;
  logic                  wrap;
  logic [3:0]            val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_r;
  logic [NUM_DIGITS-1:0] blank_r;

  logic [2:0] state, state_n;
  logic [3:0] idx_r, idx_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] widx;
  logic       we, clr, err_n, bri_we;
  logic [3:0] op, arg;

  assign op   = rx_data[7:4];
  assign arg  = rx_data[3:0];
  assign wrap = (div == DW'(SCAN_DIV - 1));

  always_ff @(posedge CLK_12_MHZ or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      ptr <= '0;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      if (wrap)
        ptr <= (ptr == PW'(NUM_DIGITS - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx_r;
    cnt_n   = cnt;
    widx    = idx_r;
    we      = 1'b0;
    clr     = 1'b0;
    err_n   = 1'b0;
    bri_we  = 1'b0;
    if (ssel) begin
      state_n = S_IDLE;
    end else if (rx_valid) begin
      unique case (state)
        S_IDLE: begin
          unique case (op)
            4'h1: begin
              if ({1'b0, arg} < 5'(NUM_DIGITS)) begin
                state_n = S_WR1;
                idx_n   = arg;
              end else begin
                err_n   = 1'b1;
                state_n = S_DISC;
              end
            end
            4'h2: begin
              state_n = S_WRA;
              cnt_n   = '0;
            end
            4'h3: clr = 1'b1;
`ifdef DISP_BRIGHTNESS_EN
            4'h4: state_n = S_WRB;
`endif
            default: begin
              err_n   = 1'b1;
              state_n = S_DISC;
            end
          endcase
        end
        S_WR1: begin
          we      = 1'b1;
          state_n = S_IDLE;
        end
        S_WRA: begin
          we   = 1'b1;
          widx = cnt;
          if (cnt == 4'(NUM_DIGITS - 1))
            state_n = S_IDLE;
          else
            cnt_n = cnt + 1'b1;
        end
`ifdef DISP_BRIGHTNESS_EN
        S_WRB: begin
          bri_we  = 1'b1;
          state_n = S_IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_12_MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx_r     <= '0;
      cnt       <= '0;
      cmd_error <= 1'b0;
    end else begin
      state     <= state_n;
      idx_r     <= idx_n;
      cnt       <= cnt_n;
      cmd_error <= err_n;
    end
  end

  always_ff @(posedge CLK_12_MHZ or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) val[i] <= '0;
      dp_r    <= '0;
      blank_r <= '1;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (clr) begin
          val[i]     <= '0;
          dp_r[i]    <= 1'b0;
          blank_r[i] <= 1'b1;
        end else if (we && widx == 4'(i)) begin
          val[i]     <= rx_data[3:0];
          dp_r[i]    <= rx_data[4];
          blank_r[i] <= rx_data[5];
        end
      end
    end
  end

  logic on;

`ifdef DISP_BRIGHTNESS_EN
  // Level is sampled at slot start so a change never cuts a slot short.
  logic [3:0]  bri, bri_slot, bri_eff;
  logic [31:0] thr;

  assign bri_eff = (div == '0) ? bri : bri_slot;
  assign thr = ((32'(bri_eff) + 32'd1) * 32'(SCAN_DIV)) >> 4;
  assign on  = 32'(div) < thr;

  always_ff @(posedge CLK_12_MHZ or negedge rst_n) begin
    if (!rst_n) begin
      bri      <= 4'd15;
      bri_slot <= 4'd15;
    end else begin
      bri_slot <= bri_eff;
      if (bri_we) bri <= rx_data[3:0];
    end
  end
`else
  assign on = 1'b1;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic                  blank_cur;
  logic [NUM_DIGITS-1:0] an_n;
  logic [7:0]            sseg_n;

  assign blank_cur = blank_r[ptr];
  assign an_n = (blank_cur || !on) ? '1 :
                ~(NUM_DIGITS'(1) << ptr);
  assign sseg_n = blank_cur ? 8'hFF :
                  {~dp_r[ptr], glyph(val[ptr])};

  always_ff @(posedge CLK_12_MHZ or negedge rst_n) begin
    if (!rst_n) begin
      an   <= '1;
      sseg <= 8'hFF;
    end else begin
      an   <= an_n;
      sseg <= sseg_n;
    end
  end

endmodule

// File: tb/tb_disp_hex_mux_cmd.sv
// Randomized scoreboard bench for disp_hex_mux_cmd.
// Expected pin states come from a frame-level model of the display.
module tb_disp_hex_mux_cmd;
  localparam int ND = 4;
  localparam int SD = 16;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          rx_valid = 0;
  logic [7:0]    rx_data = 0;
  logic          ssel = 1;
  logic [ND-1:0] an;
  logic [7:0]    sseg;
  logic          cmd_error;

  always #5 clk = ~clk;

  disp_hex_mux_cmd #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .CLK_12_MHZ(clk),
    .rst_n(rst_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .ssel(ssel),
    .an(an),
    .sseg(sseg),
    .cmd_error(cmd_error)
  );

  typedef struct packed {
    logic [ND-1:0] an;
    logic [7:0]    sseg;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                             7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0] m_val   [ND];
  bit         m_dp    [ND];
  bit         m_blank [ND];
  int         m_bri = 15;
  int         slot_bri = 15;
  bit         err_exp = 0;
  bit         running = 0;
  longint     k = 0;
  logic [7:0] wa_data [16];

  // Reference: pins after edge k show slot (k/SD)%ND at offset k%SD.
  initial forever begin
    @(posedge clk);
    if (running) begin
      int d, p;
      bit on;
      exp_t e;
      d = int'(k % SD);
      p = int'((k / SD) % ND);
      if (d == 0) slot_bri = m_bri;
`ifdef DISP_BRIGHTNESS_EN
      on = d < (((slot_bri + 1) * SD) >> 4);
`else
      on = 1;
`endif
      e.an = '1;
      e.sseg = 8'hFF;
      if (!m_blank[p]) begin
        e.sseg = {~m_dp[p], glyph[m_val[p]]};
        if (on) e.an[p] = 1'b0;
      end
      e.err = err_exp;
      err_exp = 0;
      sb.push_back(e);
      k++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if (an !== e.an || sseg !== e.sseg || cmd_error !== e.err) begin
        fails++;
        $display("FAIL pins t=%0t: an=%b sseg=%h err=%b, want an=%b sseg=%h err=%b",
                 $time, an, sseg, cmd_error, e.an, e.sseg, e.err);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    @(posedge clk);
    #1;
    rx_valid = 0;
    rx_data = 8'($urandom);
  endtask

  task automatic gap();
    idle($urandom % 3);
  endtask

  task automatic frame_begin();
    ssel = 0;
    idle(1 + $urandom % 2);
  endtask

  task automatic frame_end();
    ssel = 1;
    idle(2);
  endtask

  task automatic set_dig(int i, logic [7:0] b);
    m_val[i]   = b[3:0];
    m_dp[i]    = b[4];
    m_blank[i] = b[5];
  endtask

  task automatic cmd_write(int idx, logic [7:0] d);
    frame_begin();
    if (idx < ND) begin
      send(8'h10 | 8'(idx));
      gap();
      send(d);
      set_dig(idx, d);
    end else begin
      err_exp = 1;
      send(8'h10 | 8'(idx));
      gap();
      send(d);
      send(8'h30);
    end
    frame_end();
  endtask

  task automatic cmd_write_all(int n);
    frame_begin();
    send(8'h20 | 8'($urandom % 16));
    for (int i = 0; i < n; i++) begin
      gap();
      send(wa_data[i]);
      set_dig(i, wa_data[i]);
    end
    frame_end();
  endtask

  task automatic cmd_clear();
    frame_begin();
    send(8'h30 | 8'($urandom % 16));
    for (int i = 0; i < ND; i++) set_dig(i, 8'h20);
    frame_end();
  endtask

  task automatic cmd_bri(int b);
    frame_begin();
`ifdef DISP_BRIGHTNESS_EN
    send(8'h40 | 8'($urandom % 16));
    gap();
    send(8'(b));
    m_bri = b;
`else
    err_exp = 1;
    send(8'h40 | 8'($urandom % 16));
    gap();
    send(8'(b));
`endif
    frame_end();
  endtask

  task automatic cmd_bad(logic [3:0] op);
    frame_begin();
    err_exp = 1;
    send({op, 4'($urandom)});
    repeat ($urandom % 4) begin
      gap();
      send(8'($urandom));
    end
    frame_end();
  endtask

  // Data byte coincides with ssel rising: it must be dropped.
  task automatic cmd_drop(int idx);
    frame_begin();
    send(8'h10 | 8'(idx));
    ssel = 1;
    send(8'($urandom));
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < ND; i++) set_dig(i, 8'h20);
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (an !== '1 || sseg !== 8'hFF || cmd_error !== 1'b0) begin
      fails++;
      $display("FAIL reset: an=%b sseg=%h err=%b, want all ones/FF/0",
               an, sseg, cmd_error);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    running = 1;

    idle(2 * ND * SD + 5);
    cmd_write(2, 8'h1A);
    idle(ND * SD * 2);
    wa_data[0] = 8'h01; wa_data[1] = 8'h02;
    wa_data[2] = 8'h03; wa_data[3] = 8'h04;
    cmd_write_all(ND);
    idle(ND * SD + 3);
    wa_data[0] = 8'h1E; wa_data[1] = 8'h0C;
    cmd_write_all(2);
    idle(ND * SD);
    cmd_write(7, 8'h05);
    cmd_bad(4'h9);
    cmd_write(0, 8'h05);
    idle(ND * SD);
    cmd_clear();
    idle(ND * SD + 7);
    wa_data[0] = 8'h08; wa_data[1] = 8'h0F;
    wa_data[2] = 8'h1B; wa_data[3] = 8'h16;
    cmd_write_all(ND);
    cmd_bri(3);
    idle(2 * ND * SD);
    cmd_drop(1);
    idle(ND * SD);

    for (int it = 0; it < 90; it++) begin
      int sel;
      sel = $urandom % 8;
      case (sel)
        0, 1: cmd_write(($urandom % 5 == 0) ? $urandom_range(ND, 15)
                                            : $urandom % ND,
                        8'($urandom % 64));
        2: begin
          for (int i = 0; i < ND; i++) wa_data[i] = 8'($urandom % 64);
          cmd_write_all($urandom_range(1, ND));
        end
        3: cmd_clear();
        4: cmd_bri($urandom % 16);
        5: cmd_bad(($urandom % 2) ? 4'h0 : 4'($urandom_range(5, 15)));
        6: cmd_drop($urandom % ND);
        default: begin
          for (int i = 0; i < ND; i++) wa_data[i] = 8'($urandom % 32);
          cmd_write_all(ND);
        end
      endcase
      idle($urandom % 70);
    end

    idle(2 * ND * SD);
    running = 0;
    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
